// File: rtl/debug_loader.sv
// rtl/debug_loader.sv - UART-driven instruction loader and run/step controller for the MIPS pipeline
module debug_loader #(
  parameter int         NB_DATA     = 32,
  parameter int         NB_BYTE     = 8,
  parameter int         NB_ADDR     = 32,
  parameter int         ADDR_STEP   = 4,
  parameter int         MAX_INSTR   = 64,
  parameter logic [5:0] HALT_OPCODE = 6'b111111
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_BYTE-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_tx_ready,
  input  logic               i_pipe_halted,
  output logic [NB_BYTE-1:0] o_tx_data,
  output logic               o_tx_valid,
  output logic               o_we_IF,
  output logic [NB_DATA-1:0] o_instruction_data,
  output logic [NB_ADDR-1:0] o_inst_addr,
  output logic               o_halt,
  output logic               o_pipe_rst_n,
  output logic               o_error
);
  localparam int NB_BCNT = $clog2(NB_DATA / NB_BYTE);
  localparam int NB_WCNT = $clog2(MAX_INSTR + 1);
  localparam int NB_PART = NB_DATA - NB_BYTE;
  localparam logic [NB_BCNT-1:0] LAST_BYTE = NB_BCNT'(NB_DATA / NB_BYTE - 1);
  localparam logic [NB_WCNT-1:0] WCNT_MAX  = NB_WCNT'(MAX_INSTR);
  localparam logic [NB_ADDR-1:0] ASTEP     = NB_ADDR'(ADDR_STEP);
  localparam logic [NB_BYTE-1:0] CMD_L = NB_BYTE'(8'h4C);
  localparam logic [NB_BYTE-1:0] CMD_R = NB_BYTE'(8'h52);
  localparam logic [NB_BYTE-1:0] CMD_S = NB_BYTE'(8'h53);
  localparam logic [NB_BYTE-1:0] RSP_E = NB_BYTE'(8'h45);
  localparam logic [NB_BYTE-1:0] RSP_K = NB_BYTE'(8'h4B);
  localparam logic [NB_BYTE-1:0] RSP_D = NB_BYTE'(8'h44);

  typedef enum logic [2:0] {IDLE, LOAD, WRITE, PIPE_RST, RUN, STEP, RESP} state_t;

  state_t             state_q, state_d;
  logic [NB_BCNT-1:0] byte_cnt_q, byte_cnt_d;
  logic [NB_WCNT-1:0] word_cnt_q, word_cnt_d;
  logic [NB_PART-1:0] part_q, part_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
  logic we_q, we_d, halt_q, halt_d, prst_n_q, prst_n_d;
  logic tx_valid_q, tx_valid_d, err_q, err_d, sub_q, sub_d;

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      part_q     <= '0;
      data_q     <= '0;
      addr_q     <= '0;
      tx_data_q  <= '0;
      we_q       <= 1'b0;
      halt_q     <= 1'b1;
      prst_n_q   <= 1'b0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
      sub_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      part_q     <= part_d;
      data_q     <= data_d;
      addr_q     <= addr_d;
      tx_data_q  <= tx_data_d;
      we_q       <= we_d;
      halt_q     <= halt_d;
      prst_n_q   <= prst_n_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
      sub_q      <= sub_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    part_d     = part_q;
    data_d     = data_q;
    addr_d     = addr_q;
    tx_data_d  = tx_data_q;
    we_d       = 1'b0;
    halt_d     = halt_q;
    prst_n_d   = 1'b1;  // only PIPE_RST holds the pipeline in reset
    tx_valid_d = tx_valid_q;
    err_d      = err_q;
    sub_d      = sub_q;
    case (state_q)
      IDLE: if (i_rx_valid) begin
        case (i_rx_data)
          CMD_L: begin
            state_d = LOAD; addr_d = '0; byte_cnt_d = '0; word_cnt_d = '0; err_d = 1'b0;
          end
          CMD_R: begin state_d = RUN; err_d = 1'b0; end
          CMD_S: begin state_d = STEP; sub_d = 1'b0; err_d = 1'b0; end
          default: begin
            err_d = 1'b1; tx_data_d = RSP_E; tx_valid_d = 1'b1; state_d = RESP;
          end
        endcase
      end
      LOAD: if (i_rx_valid) begin
        if (byte_cnt_q == LAST_BYTE) begin
          data_d = {part_q, i_rx_data}; we_d = 1'b1; byte_cnt_d = '0; state_d = WRITE;
        end else begin
          part_d = {part_q[NB_PART-NB_BYTE-1:0], i_rx_data};
          byte_cnt_d = byte_cnt_q + 1'b1;
        end
      end
      WRITE: begin
        addr_d     = addr_q + ASTEP;
        word_cnt_d = word_cnt_q + 1'b1;
        if (data_q[NB_DATA-1 -: 6] == HALT_OPCODE) begin
          prst_n_d = 1'b0; halt_d = 1'b1; sub_d = 1'b0; state_d = PIPE_RST;
        end else if (word_cnt_d == WCNT_MAX) begin
          err_d = 1'b1; tx_data_d = RSP_E; tx_valid_d = 1'b1; state_d = RESP;
        end else begin
          state_d = LOAD;
        end
      end
      PIPE_RST: begin
        if (!sub_q) begin
          prst_n_d = 1'b0; sub_d = 1'b1;
        end else begin
          tx_data_d = RSP_K; tx_valid_d = 1'b1; state_d = RESP;
        end
      end
      RUN: begin
        if (i_pipe_halted) begin
          halt_d = 1'b1; tx_data_d = RSP_D; tx_valid_d = 1'b1; state_d = RESP;
        end else begin
          halt_d = 1'b0;
        end
      end
      STEP: begin
        // phase 0 opens the halt gate for one cycle, phase 1 closes it again
        if (!sub_q) begin
          if (i_pipe_halted) begin
            tx_data_d = RSP_D; tx_valid_d = 1'b1; state_d = RESP;
          end else begin
            halt_d = 1'b0; sub_d = 1'b1;
          end
        end else begin
          halt_d = 1'b1; tx_data_d = RSP_K; tx_valid_d = 1'b1; state_d = RESP;
        end
      end
      RESP: if (i_tx_ready) begin
        tx_valid_d = 1'b0; state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_tx_data          = tx_data_q;
  assign o_tx_valid         = tx_valid_q;
  assign o_we_IF            = we_q;
  assign o_instruction_data = data_q;
  assign o_inst_addr        = addr_q;
  assign o_halt             = halt_q;
  assign o_pipe_rst_n       = prst_n_q;
  assign o_error            = err_q;
endmodule
